instr_fetch_ctrl: RTL and testbench

- Sequences the instruction memory for the IF stage.
- Owns the PC and drives a stable word-aligned fetch address.
- Waits a fixed number of cycles for the memory read data to settle, then presents the instruction and its PC to decode over a valid/ready handshake.
- Handles decode back-pressure and branch/jump redirects, including aborting a fetch already in flight.

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/fetch_lat_counter.sv | 38 +++
 rtl/instr_fetch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional build macro used by the top level: FETCH_PERF_EN.
package ifetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_lat_counter.sv
// Loadable down-counter with a zero flag; times the memory read latency.
// A load always wins over a decrement; decrementing stops at zero.
module fetch_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load, otherwise saturating decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues word-aligned fetches,
// waits MEM_LAT cycles for read data and hands the instruction to decode
// over a valid/ready handshake. Redirects abort any fetch in flight.
// Define FETCH_PERF_EN to add the fetch/stall performance counters.
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MEM_LAT  = 2,
    parameter int                CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_req,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    // MEM_LAT must be >= 1 and 2**CNT_W must exceed MEM_LAT.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_RESET   = RESET_PC & ALIGN_MASK;
    localparam logic [CNT_W-1:0]  LAT_LOAD   = CNT_W'(MEM_LAT - 1);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_req_q, mem_req_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero;

    fetch_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state logic: redirect first, then per-state sequencing
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = mem_req_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (redirect_valid) begin
            // Drop whatever is in flight or presented; refetch from IDLE
            pc_d         = redirect_pc & ALIGN_MASK;
            out_valid_d  = 1'b0;
            mem_req_d    = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
            state_d      = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        mem_addr_d   = pc_q;
                        mem_req_d    = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = LAT_LOAD;
                        state_d      = WAIT;
                    end
                end
                WAIT: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        // Read data has settled: capture it and advance the PC
                        out_instr_d = mem_rdata;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + ADDR_W'(PC_STEP);
                        mem_req_d   = 1'b0;
                        state_d     = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (enable) begin
                            // Issue the next fetch on the accepting edge
                            mem_addr_d   = pc_q;
                            mem_req_d    = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_load_val = LAT_LOAD;
                            state_d      = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, PC and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= PC_RESET;
            mem_addr_q  <= PC_RESET;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_req   = mem_req_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Count accepted (non-squashed) handshakes and back-pressure cycles
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (out_valid_q && out_ready && !redirect_valid) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if ((state_q == HOLD) && !out_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a transaction-level model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_instr_fetch_ctrl;

    localparam int MEM_LAT = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    // Narrow-PC instance for the wrap scenario
    logic        w_reset;
    logic [7:0]  w_mem_addr;
    logic        w_mem_req;
    logic [31:0] w_mem_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [7:0]  w_out_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    logic [31:0] w_perf_fetch_cnt, w_perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    assign mem_rdata   = word_of(mem_addr);
    assign w_mem_rdata = word_of({24'h0, w_mem_addr});

    instr_fetch_ctrl #(
        .ADDR_W (32), .RESET_PC (32'h0), .MEM_LAT (MEM_LAT), .CNT_W (4)
    ) u_dut (
        .clk (clk), .reset (reset), .enable (enable),
        .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
        .mem_addr (mem_addr), .mem_req (mem_req), .mem_rdata (mem_rdata),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_instr (out_instr), .out_pc (out_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt (perf_fetch_cnt), .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    instr_fetch_ctrl #(
        .ADDR_W (8), .RESET_PC (8'hFC), .MEM_LAT (MEM_LAT), .CNT_W (4)
    ) u_wrap (
        .clk (clk), .reset (w_reset), .enable (1'b1),
        .redirect_valid (1'b0), .redirect_pc (8'h00),
        .mem_addr (w_mem_addr), .mem_req (w_mem_req), .mem_rdata (w_mem_rdata),
        .out_valid (w_out_valid), .out_ready (1'b1),
        .out_instr (w_out_instr), .out_pc (w_out_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt (w_perf_fetch_cnt), .perf_stall_cnt (w_perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Fetch life cycle: idle -> address held for MEM_LAT cycles -> presented
    // until accepted. age counts the cycles the current address has been held.
    logic [31:0] m_pc, m_addr, m_instr, m_opc;
    logic        m_req, m_valid;
    int          m_age;
    logic [31:0] m_fetch, m_stall;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_addr = 0; m_req = 0; m_valid = 0;
            m_instr = 0; m_opc = 0; m_age = 0; m_fetch = 0; m_stall = 0;
        end else begin
            if (m_valid && !out_ready) m_stall = m_stall + 1;
            if (redirect_valid) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_valid = 0;
                m_req = 0;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_fetch = m_fetch + 1;
                    m_valid = 0;
                    if (enable) begin
                        m_addr = m_pc; m_req = 1; m_age = 0;
                    end
                end
            end else if (m_req) begin
                if (m_age + 1 == MEM_LAT) begin
                    m_instr = word_of(m_addr);
                    m_opc = m_pc;
                    m_pc = m_pc + 4;
                    m_req = 0;
                    m_valid = 1;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (enable) begin
                m_addr = m_pc; m_req = 1; m_age = 0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("cmp_mem_addr", mem_addr, m_addr);
        check("cmp_mem_req", {31'b0, mem_req}, {31'b0, m_req});
        check("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("cmp_out_instr", out_instr, m_instr);
        check("cmp_out_pc", out_pc, m_opc);
`ifdef FETCH_PERF_EN
        check("cmp_perf_fetch", perf_fetch_cnt, m_fetch);
        check("cmp_perf_stall", perf_stall_cnt, m_stall);
`endif
    end

    // Wrap instance: log every presented PC (ready is tied high)
    logic [7:0] w_pcs[$];
    always @(negedge clk) begin
        if (!w_reset && w_out_valid) w_pcs.push_back(w_out_pc);
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic wait_valid(input string tag, output logic [31:0] pc,
                              output logic [31:0] ins, output int at);
        bit found = 0;
        pc = 'x; ins = 'x; at = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1; pc = out_pc; ins = out_instr; at = cyc;
            end
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL %s: timeout waiting for out_valid", tag);
        end
    endtask

    task automatic wait_valid_pc(input string tag, input logic [31:0] target);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_pc == target) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: timeout waiting for out_pc %h", tag, target);
        end
    endtask

    logic [31:0] pc, ins;
    int t0, t1;

    initial begin
        reset = 1; w_reset = 1; enable = 0; out_ready = 1;
        redirect_valid = 0; redirect_pc = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_wrap_addr", {24'h0, w_mem_addr}, 32'hFC);

        // Free-running fetch
        reset = 0; w_reset = 0; enable = 1;
        @(negedge clk);
        check("issue0_req", {31'b0, mem_req}, 32'h1);
        check("issue0_addr", mem_addr, 32'h0);
        wait_valid("seq0", pc, ins, t0);
        check("seq0_pc", pc, 32'h0);
        check("seq0_instr", ins, 32'hA000_0000);
        wait_valid("seq1", pc, ins, t1);
        check("seq1_pc", pc, 32'h4);
        check("seq1_instr", ins, 32'hA000_0001);
        check("seq1_gap", t1 - t0, 3);
        t0 = t1;
        wait_valid("seq2", pc, ins, t1);
        check("seq2_pc", pc, 32'h8);
        check("seq2_instr", ins, 32'hA000_0002);
        check("seq2_gap", t1 - t0, 3);

        // Back-pressure while holding pc 0x10
        wait_valid_pc("bp_reach", 32'h10);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'h1);
            check("bp_pc", out_pc, 32'h10);
            check("bp_instr", out_instr, 32'hA000_0004);
            check("bp_req", {31'b0, mem_req}, 32'h0);
            check("bp_addr", mem_addr, 32'h10);
        end
        out_ready = 1;
        @(negedge clk);
        check("bp_next_addr", mem_addr, 32'h14);
        check("bp_next_req", {31'b0, mem_req}, 32'h1);
        check("bp_next_valid", {31'b0, out_valid}, 32'h0);

        // Redirect coincident with an accepted handshake at pc 0x20
        wait_valid_pc("co_reach", 32'h20);
        redirect_valid = 1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect_valid = 0;
        check("co_valid", {31'b0, out_valid}, 32'h0);
        check("co_req", {31'b0, mem_req}, 32'h0);
        wait_valid("co_next", pc, ins, t1);
        check("co_next_pc", pc, 32'h80);
        check("co_next_instr", ins, 32'hA000_0020);

        // Redirect while the fetch of 0x84 is in flight
        @(negedge clk);
        check("mw_addr", mem_addr, 32'h84);
        redirect_valid = 1; redirect_pc = 32'h107;
        @(negedge clk);
        redirect_valid = 0;
        check("mw_req_drop", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        check("mw_refetch_addr", mem_addr, 32'h104);
        check("mw_refetch_req", {31'b0, mem_req}, 32'h1);
        wait_valid("mw_next", pc, ins, t1);
        check("mw_next_pc", pc, 32'h104);
        check("mw_next_instr", ins, 32'hA000_0041);

        // enable falls mid-WAIT: the fetch completes, nothing further issues
        @(negedge clk);
        enable = 0;
        wait_valid("en_fall", pc, ins, t1);
        check("en_fall_pc", pc, 32'h108);
        repeat (4) @(negedge clk);
        check("en_idle_req", {31'b0, mem_req}, 32'h0);
        check("en_idle_valid", {31'b0, out_valid}, 32'h0);
        enable = 1;

        // Asynchronous reset while holding pc 0x8
        reset = 1;
        @(negedge clk);
        reset = 0;
        wait_valid_pc("ar_reach", 32'h8);
        out_ready = 0;
        @(negedge clk);
        check("ar_hold_pc", out_pc, 32'h8);
        #2 reset = 1;
        #1;
        check("ar_valid_async", {31'b0, out_valid}, 32'h0);
        check("ar_pc_async", out_pc, 32'h0);
        check("ar_addr_async", mem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 0; out_ready = 1;
        @(negedge clk);
        check("ar_refetch_addr", mem_addr, 32'h0);
        check("ar_refetch_req", {31'b0, mem_req}, 32'h1);
        wait_valid("ar_first", pc, ins, t1);
        check("ar_first_pc", pc, 32'h0);
        check("ar_first_instr", ins, 32'hA000_0000);

        // Wrap sequence from the 8-bit instance
        check("wrap_count_ge3", {31'b0, w_pcs.size() >= 3}, 32'h1);
        if (w_pcs.size() >= 3) begin
            check("wrap_pc0", {24'h0, w_pcs[0]}, 32'hFC);
            check("wrap_pc1", {24'h0, w_pcs[1]}, 32'h00);
            check("wrap_pc2", {24'h0, w_pcs[2]}, 32'h04);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
